mulacc: RTL and testbench

- Sequential shift-add multiply-accumulate unit. Computes res = a*b + c on unsigned WIDTH-bit operands.
- Inverse of the divrem block: takes a quotient/denominator/remainder triple and rebuilds the numerator. Used by the prime generator's self-check path to cross-check divider results.
- Uses the same go/ready/error handshake as divrem, so both blocks can share one sequencer.

---
 rtl/mulacc.sv | 161 ++++++++++++++++
 tb/tb_mulacc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mulacc.sv
// ---------------------------------------------------------------------------
// mulacc -- sequential shift-add multiply-accumulate unit
//
// Computes res = a*b + c on unsigned WIDTH-bit operands, one multiplier bit
// per clock, LSB first. This is the inverse of the divrem block: feeding it
// quotient/denominator/remainder rebuilds the numerator. It uses the same
// go/ready/error handshake as divrem, so one sequencer can drive both.
//
// Parameters:
//   WIDTH  operand and result width in bits (2..32)
//
// Ports:
//   clk    input   clock, all state updates on posedge
//   rst    input   synchronous active-high reset (wins over go)
//   go     input   start request, sampled at posedge while idle
//   a      input   multiplicand (quotient side)
//   b      input   multiplier (denominator side)
//   c      input   addend (remainder side)
//   ready  output  1 = idle, res/error valid
//   error  output  1 = last a*b+c did not fit in WIDTH bits
//   res    output  low WIDTH bits of a*b+c
//
// Optional build macro:
//   MULACC_EARLY_EXIT_EN  when defined, RUN also finishes as soon as the
//                         remaining multiplier bits are all zero, so the
//                         busy time becomes max(1, bitlen(b)) cycles.
// ---------------------------------------------------------------------------
module mulacc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] res
);

  // Accumulator is 2*WIDTH+1 bits: (2^W-1)^2 + (2^W-1) always fits, so the
  // overflow flag can be read straight from the bits above WIDTH.
  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic            err_q, err_d;

  logic [AW-1:0]   accSum;
  logic            lastStep;

  // One partial-product step: add the shifted multiplicand when the current
  // multiplier bit is set.
  assign accSum = acc_q + (b_q[0] ? mcand_q : '0);

  // The final RUN cycle is normally the WIDTH-th one. With early exit, we can
  // also stop once no set multiplier bits remain after this cycle's shift.
  always_comb begin
    lastStep = (cnt_q == LAST_CNT);
`ifdef MULACC_EARLY_EXIT_EN
    lastStep = lastStep | ((b_q >> 1) == '0);
`else
    lastStep = lastStep | 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: go only matters while idle, so a request during RUN
  // is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (lastStep) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ready = (state_q == IDLE);
    error = err_q;
    res   = res_q;
  end

  // Datapath next-state. Starting an operation clears error but leaves res
  // showing the previous result until the new one is written at exit.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          acc_d   = {{(AW - WIDTH){1'b0}}, c};
          mcand_d = {{(AW - WIDTH){1'b0}}, a};
          b_d     = b;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        acc_d   = accSum;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (lastStep) begin
          res_d = accSum[WIDTH-1:0];
          err_d = |accSum[AW-1:WIDTH];
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Datapath registers. Reset also wipes any partial result of an aborted
  // operation so it can never be presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mulacc.sv
// ---------------------------------------------------------------------------
// tb_mulacc -- self-checking bench for mulacc (WIDTH=16)
//
// Directed vectors with hand-computed results, followed by hand-written
// sequences for reset, busy-go, abort and a divrem round-trip sweep.
// Honours MULACC_EARLY_EXIT_EN when computing expected busy time.
// ---------------------------------------------------------------------------
module tb_mulacc;

  localparam int W = 16;
  localparam int TIMEOUT = 100;

`ifdef MULACC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] c   = '0;
  logic         ready;
  logic         error;
  logic [W-1:0] res;

  int checks = 0;
  int errors = 0;

  mulacc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .a     (a),
    .b     (b),
    .c     (c),
    .ready (ready),
    .error (error),
    .res   (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] expRes;
    logic         expErr;
  } vec_t;

  vec_t vecs[10];

  // Expected busy time for a given multiplier value.
  function automatic int expLat(input logic [W-1:0] bv);
    int n;
    if (!EARLY) return W;
    n = 0;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
    return (n < 1) ? 1 : n;
  endfunction

  // Compare one value and report it.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation at a negedge, pulse go for one edge, then count the
  // negedges on which ready is low. Returns the result and the busy count.
  task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi,
                               input logic [W-1:0] ci, output logic [W-1:0] r,
                               output logic e, output int cyc);
    @(negedge clk);
    a  = ai;
    b  = bi;
    c  = ci;
    go = 1'b1;
    @(negedge clk);
    go  = 1'b0;
    cyc = 0;
    while (!ready && cyc < TIMEOUT) begin
      cyc++;
      @(negedge clk);
    end
    r = res;
    e = error;
  endtask

  logic [W-1:0] r;
  logic         e;
  int           cyc;

  initial begin
    vecs[0] = '{a: 16'd3,      b: 16'd5,      c: 16'd2,      expRes: 16'd17,     expErr: 1'b0};
    vecs[1] = '{a: 16'd255,    b: 16'd257,    c: 16'd0,      expRes: 16'd65535,  expErr: 1'b0};
    vecs[2] = '{a: 16'd256,    b: 16'd256,    c: 16'd0,      expRes: 16'd0,      expErr: 1'b1};
    vecs[3] = '{a: 16'hFFFF,   b: 16'd1,      c: 16'd1,      expRes: 16'd0,      expErr: 1'b1};
    vecs[4] = '{a: 16'hFFFF,   b: 16'hFFFF,   c: 16'hFFFF,   expRes: 16'h0000,   expErr: 1'b1};
    vecs[5] = '{a: 16'd0,      b: 16'd1234,   c: 16'd77,     expRes: 16'd77,     expErr: 1'b0};
    vecs[6] = '{a: 16'd1234,   b: 16'd0,      c: 16'd77,     expRes: 16'd77,     expErr: 1'b0};
    vecs[7] = '{a: 16'd100,    b: 16'd200,    c: 16'd5,      expRes: 16'd20005,  expErr: 1'b0};
    vecs[8] = '{a: 16'd1000,   b: 16'd70,     c: 16'd0,      expRes: 16'd4464,   expErr: 1'b1};
    vecs[9] = '{a: 16'd1,      b: 16'h8000,   c: 16'd5,      expRes: 16'd32773,  expErr: 1'b0};

    // Reset with go held high: nothing may start.
    @(negedge clk);
    rst = 1'b1;
    go  = 1'b1;
    @(negedge clk);
    checkOutput("reset ready", ready, 1);
    checkOutput("reset error", error, 0);
    checkOutput("reset res", res, 0);
    rst = 1'b0;
    go  = 1'b0;
    @(negedge clk);
    checkOutput("post-reset ready", ready, 1);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, r, e, cyc);
      checkOutput($sformatf("vec%0d res", i), r, vecs[i].expRes);
      checkOutput($sformatf("vec%0d error", i), e, vecs[i].expErr);
      checkOutput($sformatf("vec%0d latency", i), cyc, expLat(vecs[i].b));
    end

    // Busy: a second go with different operands mid-run is ignored.
    @(negedge clk);
    a  = 16'd1;
    b  = 16'h8000;
    c  = 16'd5;
    go = 1'b1;
    @(negedge clk);
    go  = 1'b0;
    cyc = 0;
    while (!ready && cyc < TIMEOUT) begin
      cyc++;
      if (cyc == 5) begin
        a  = 16'd100;
        b  = 16'd200;
        c  = 16'd9;
        go = 1'b1;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
    end
    go = 1'b0;
    checkOutput("busy res", res, 32773);
    checkOutput("busy error", error, 0);
    checkOutput("busy latency", cyc, 16);
    @(negedge clk);
    checkOutput("busy no restart", ready, 1);

    // Abort: reset during RUN discards the partial result.
    a  = 16'd1;
    b  = 16'h8000;
    c  = 16'd5;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("abort busy", ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort ready", ready, 1);
    checkOutput("abort res", res, 0);
    checkOutput("abort error", error, 0);
    applyStimulus(16'd3, 16'd5, 16'd2, r, e, cyc);
    checkOutput("after abort res", r, 17);
    checkOutput("after abort latency", cyc, expLat(16'd5));

    // divrem round trip: quot*den + rem must rebuild num without overflow.
    for (int num = 0; num < 20; num++) begin
      for (int den = 1; den < 20; den++) begin
        applyStimulus(W'(num / den), W'(den), W'(num % den), r, e, cyc);
        checkOutput($sformatf("rt %0d/%0d res", num, den), r, num);
        checkOutput($sformatf("rt %0d/%0d error", num, den), e, 0);
        checkOutput($sformatf("rt %0d/%0d latency", num, den), cyc, expLat(W'(den)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
